// File: rtl/adder_pipe.sv
// adder_pipe: pipelined add/sub with valid/ready handshake and carry/overflow/zero flags; optional saturation via ADDER_PIPE_SAT_EN
module adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             sub,
`ifdef ADDER_PIPE_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int SW = WIDTH / STAGES;
  logic en;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [WIDTH-1:0] a_i, b_i, r_i, bx, r_n;
    logic             v_i, c_i, s_i, v_r;
    logic [SW:0]      sum;
`ifdef ADDER_PIPE_SAT_EN
    logic             t_i;
`endif
    if (k == 0) begin : g_in
      assign a_i = op1;
      assign b_i = op2;
      assign r_i = '0;
      assign c_i = sub;
      assign s_i = sub;
      assign v_i = in_valid;
`ifdef ADDER_PIPE_SAT_EN
      assign t_i = sat;
`endif
    end else begin : g_in
      assign a_i = g_st[k-1].g_fwd.a_r;
      assign b_i = g_st[k-1].g_fwd.b_r;
      assign r_i = g_st[k-1].g_fwd.r_r;
      assign c_i = g_st[k-1].g_fwd.c_r;
      assign s_i = g_st[k-1].g_fwd.s_r;
      assign v_i = g_st[k-1].v_r;
`ifdef ADDER_PIPE_SAT_EN
      assign t_i = g_st[k-1].g_fwd.t_r;
`endif
    end
    assign bx  = b_i ^ {WIDTH{s_i}};
    assign sum = {1'b0, a_i[k*SW +: SW]} + {1'b0, bx[k*SW +: SW]} + (SW+1)'(c_i);
    // splice this stage's sum slice into the partial result
    always_comb begin
      r_n = r_i;
      r_n[k*SW +: SW] = sum[SW-1:0];
    end
    // stage valid bit, frozen while the output is stalled
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) v_r <= 1'b0;
      else if (en) v_r <= v_i;
    if (k < STAGES-1) begin : g_fwd
      logic [WIDTH-1:0] a_r, b_r, r_r;
      logic             c_r, s_r;
`ifdef ADDER_PIPE_SAT_EN
      logic             t_r;
      // sat travels alongside its operands
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) t_r <= 1'b0;
        else if (en) t_r <= t_i;
`endif
      // carry the operands, partial result and slice carry to the next stage
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
          r_r <= '0;
          c_r <= 1'b0;
          s_r <= 1'b0;
        end else if (en) begin
          a_r <= a_i;
          b_r <= b_i;
          r_r <= r_n;
          c_r <= sum[SW];
          s_r <= s_i;
        end
    end else begin : g_out
      logic             ov;
      logic [WIDTH-1:0] rs;
      assign ov = (a_i[WIDTH-1] == bx[WIDTH-1]) && (r_n[WIDTH-1] != a_i[WIDTH-1]);
`ifdef ADDER_PIPE_SAT_EN
      assign rs = (t_i && ov) ? {a_i[WIDTH-1], {(WIDTH-1){!a_i[WIDTH-1]}}} : r_n;
`else
      assign rs = r_n;
`endif
      // final stage registers the full result and its flags
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          result    <= '0;
          carry_out <= 1'b0;
          overflow  <= 1'b0;
          zero      <= 1'b0;
        end else if (en) begin
          result    <= rs;
          carry_out <= sum[SW];
          overflow  <= ov;
          zero      <= ~|rs;
        end
    end
  end
  assign out_valid = g_st[STAGES-1].v_r;
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: scoreboard bench for adder_pipe (WIDTH=32, STAGES=2)
module tb_adder_pipe;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, sub, out_valid, out_ready;
  logic [31:0] op1, op2, result;
  logic        carry_out, overflow, zero;
`ifdef ADDER_PIPE_SAT_EN
  logic        sat;
`endif
  int          vectors = 0;
  int          errors = 0;
  logic [34:0] sb [$];
  logic [34:0] e;

  adder_pipe #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .sub(sub),
`ifdef ADDER_PIPE_SAT_EN
    .sat(sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] expect_of(input logic [31:0] a, b, input logic s, input logic st);
    logic [31:0] bb, r;
    logic [32:0] t;
    logic        v;
    bb = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {32'd0, s};
    v  = (a[31] == bb[31]) && (t[31] != a[31]);
    r  = (st && v) ? (a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : t[31:0];
    return {r, t[32], v, r == 32'd0};
  endfunction

  // scoreboard: push on acceptance, pop and compare on delivery
  always @(negedge clk)
    if (rst_n) begin
      if (in_valid && in_ready)
`ifdef ADDER_PIPE_SAT_EN
        sb.push_back(expect_of(op1, op2, sub, sat));
`else
        sb.push_back(expect_of(op1, op2, sub, 1'b0));
`endif
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got result=%h", result);
        end else begin
          e = sb.pop_front();
          if ({result, carry_out, overflow, zero} !== e) begin
            errors++;
            $display("FAIL scoreboard got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
                     result, carry_out, overflow, zero, e[34:3], e[2], e[1], e[0]);
          end
        end
      end
    end

  task automatic drive(input logic [31:0] a, b, input logic s);
    int n = 0;
    op1 = a; op2 = b; sub = s; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++; errors++;
      $display("FAIL in_ready_timeout got 0 want 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      vectors++; errors++;
      $display("FAIL out_valid_timeout got 0 want 1");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({out_valid, result, carry_out, overflow, zero} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b r=%h c=%b o=%b z=%b want all 0", out_valid, result, carry_out, overflow, zero);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive(32'd5, 32'd4, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency_early got out_valid=%b want 0", out_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if ({out_valid, result, carry_out, overflow, zero} !== {1'b1, 32'd9, 3'b000}) begin
      errors++;
      $display("FAIL basic_add got v=%b r=%h c=%b o=%b z=%b want v=1 r=9 c=0 o=0 z=0", out_valid, result, carry_out, overflow, zero);
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(32'd5, 32'd4, 1'b0);
    drive(32'd11, 32'd8, 1'b1);
    drive(32'd65, 32'd100, 1'b0);
    vectors++;
    if ({out_valid, result, carry_out} !== {1'b1, 32'd3, 1'b1}) begin
      errors++;
      $display("FAIL b2b_second got v=%b r=%h c=%b want v=1 r=3 c=1", out_valid, result, carry_out);
    end
    @(posedge clk); #1;
    vectors++;
    if ({out_valid, result} !== {1'b1, 32'd165}) begin
      errors++;
      $display("FAIL b2b_third got v=%b r=%h want v=1 r=a5", out_valid, result);
    end
    idle(3);
  endtask

  task automatic test_boundary();
    out_ready = 1'b1;
    drive(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_out();
    vectors++;
    if ({result, carry_out, overflow, zero} !== {32'd0, 3'b101}) begin
      errors++;
      $display("FAIL wrap_to_zero got r=%h c=%b o=%b z=%b want r=0 c=1 o=0 z=1", result, carry_out, overflow, zero);
    end
    idle(3);
    drive(32'h7FFF_FFFF, 32'd1, 1'b0);
    wait_out();
    vectors++;
    if ({result, carry_out, overflow, zero} !== {32'h8000_0000, 3'b010}) begin
      errors++;
      $display("FAIL pos_overflow got r=%h c=%b o=%b z=%b want r=80000000 c=0 o=1 z=0", result, carry_out, overflow, zero);
    end
    idle(3);
  endtask

  task automatic test_cross_slice();
    out_ready = 1'b1;
    drive(32'h0000_FFFF, 32'd1, 1'b0);
    wait_out();
    vectors++;
    if (result !== 32'h0001_0000) begin
      errors++;
      $display("FAIL cross_carry got %h want 00010000", result);
    end
    idle(3);
    drive(32'd0, 32'd1, 1'b1);
    wait_out();
    vectors++;
    if ({result, carry_out, overflow, zero} !== {32'hFFFF_FFFF, 3'b000}) begin
      errors++;
      $display("FAIL sub_borrow got r=%h c=%b o=%b z=%b want r=ffffffff c=0 o=0 z=0", result, carry_out, overflow, zero);
    end
    idle(3);
  endtask

`ifdef ADDER_PIPE_SAT_EN
  task automatic test_sat();
    out_ready = 1'b1;
    sat = 1'b1;
    drive(32'h7FFF_FFFF, 32'd1, 1'b0);
    wait_out();
    vectors++;
    if ({result, carry_out, overflow, zero} !== {32'h7FFF_FFFF, 3'b010}) begin
      errors++;
      $display("FAIL sat_pos got r=%h c=%b o=%b z=%b want r=7fffffff c=0 o=1 z=0", result, carry_out, overflow, zero);
    end
    idle(3);
    drive(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_out();
    vectors++;
    if ({result, carry_out, overflow, zero} !== {32'h8000_0000, 3'b110}) begin
      errors++;
      $display("FAIL sat_neg got r=%h c=%b o=%b z=%b want r=80000000 c=1 o=1 z=0", result, carry_out, overflow, zero);
    end
    idle(3);
    sat = 1'b0;
  endtask
`endif

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(32'd10, 32'd20, 1'b0);
    drive(32'd7, 32'd9, 1'b1);
    repeat (3) begin
      vectors++;
      if ({out_valid, in_ready, result} !== {2'b10, 32'd30}) begin
        errors++;
        $display("FAIL stall_hold got v=%b in_ready=%b r=%h want v=1 in_ready=0 r=1e", out_valid, in_ready, result);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({out_valid, result} !== {1'b1, 32'hFFFF_FFFE}) begin
      errors++;
      $display("FAIL stall_release got v=%b r=%h want v=1 r=fffffffe", out_valid, result);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL stall_drain got v=%b pending=%0d want v=0 pending=0", out_valid, sb.size());
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive(32'd1, 32'd2, 1'b0);
    drive(32'd3, 32'd4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, result} !== 33'd0) begin
      errors++;
      $display("FAIL async_reset got v=%b r=%h want v=0 r=0", out_valid, result);
    end
    sb.delete();
    #3 rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready got %b want 1", in_ready);
    end
    repeat (4) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_output got v=%b r=%h want v=0", out_valid, result);
      end
    end
  endtask

  task automatic test_random();
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(4);
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL random_drain got pending=%0d want 0", sb.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; op1 = '0; op2 = '0;
`ifdef ADDER_PIPE_SAT_EN
    sat = 1'b0;
`endif
    test_reset();
    test_basic();
    test_back_to_back();
    test_boundary();
    test_cross_slice();
`ifdef ADDER_PIPE_SAT_EN
    test_sat();
`endif
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
